mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath: executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the architectural HI/LO registers. It sits directly downstream of the register-file read stage, alongside the 32-bit ripple adder and 2:1 muxes. It reuses one 32-bit adder per iteration step, instantiated through the team's gate-level adder, for shift-add multiplication and restoring division. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request operation; sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `a` in 32: rs operand (multiplicand / dividend); sampled with `start`.
- `b` in 32: rt operand (multiplier / divisor); sampled with `start`.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `div_by_zero` out 1: last completed divide had `b`==0.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE with `start`=1: latch `op`, `a`, `b`.
  - Signed ops: latch |a| and |b|, and record sign(a) and sign(b).
  - Clear the 6-bit iteration counter; go to RUN.
- RUN: one iteration per cycle for exactly 32 cycles, then FINISH.
  - Multiply: 64-bit accumulator {P_hi, P_lo}, with P_lo initialised to the multiplier. Each step: if P_lo[0]==1, add the multiplicand to P_hi (33-bit sum keeps the carry). Then shift {carry, P_hi, P_lo} right by 1.
  - Divide (restoring): remainder R (33 bits) and quotient Q, with Q initialised to the dividend. Each step: shift {R, Q} left by 1 and trial-subtract the divisor from R. The subtraction is an add of ~divisor with carry-in 1. If the result is non-negative, keep it and set Q[0]=1; otherwise restore R and set Q[0]=0.
- FINISH: apply the sign fixup, write `hi`/`lo`, pulse `done`, return to IDLE.
  - MULT: negate the 64-bit product if sign(a)≠sign(b). Result goes to {hi, lo}.
  - MULTU: the unsigned product goes to {hi, lo}.
  - DIV and DIVU: quotient goes to `lo`, remainder to `hi`.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero (DIV or DIVU, `b`==0):
  - Full latency is still used.
  - Result: `hi`=original `a`, `lo`=0xFFFFFFFF; no sign fixup.
  - `div_by_zero` is set to 1 at FINISH.
- `div_by_zero` behaviour outside the zero case:
  - Cleared at FINISH of any other operation.
  - Held otherwise.
- `hi`/`lo` are updated only at FINISH or by MTHI/MTLO; they hold their previous values throughout RUN.
- MTHI/MTLO rules:
  - `hi_we`/`lo_we` are honoured only when `busy`=0 and are ignored during RUN and FINISH.
  - If a write and `start` occur in the same IDLE cycle, the write lands, then is overwritten at FINISH.
- `start` while `busy`=1 is ignored; it is not queued.

## Timing
- Reset values: IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter=0.
- Reset mid-operation aborts immediately with the same values.
- `reset` takes priority over `start` and over writes.
- Edge E0 (`start` sampled in IDLE): `busy` goes 1.
- Edges E1..E32: the 32 iterations.
- Edge E33 (FINISH):
  - `hi`/`lo` take the result, `done`=1 and `busy`=0 for the cycle after E33.
  - Total latency is 33 cycles from the start edge to the visible result.
- `done` is high for exactly one cycle.
- Back-to-back operation: a new `start` is accepted in the `done` cycle (state is IDLE), so its E0 coincides with the edge that ends `done`.
- `busy` is registered and high for exactly 33 cycles per operation.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, one `done` pulse, `busy` high for exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6. Then MULT a=0x80000000, b=0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV a=-7, b=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIVU a=100, b=7 -> `lo`=14, `hi`=2. DIV 0x80000000 / -1 -> `lo`=0x80000000, `hi`=0.
- DIVU a=0x1234, b=0 -> `hi`=0x1234, `lo`=0xFFFFFFFF, `div_by_zero`=1. A following MULTU 3×5 clears it: `lo`=15, `hi`=0.
- Protocol check:
  - A second `start` and `hi_we` pulse at cycle 10 of RUN have no effect.
  - MTLO 0xA5A5A5A5 in IDLE -> `lo` updates next cycle.
  - `start` in the `done` cycle is accepted.
- `reset` asserted at cycle 15 of a DIV -> next cycle IDLE, `busy`=0, `hi`=`lo`=0, no `done`. A subsequent MULTU 2×3 gives `lo`=6.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit holding HI/LO
// One shared ripple adder serves both shift-add multiply and restoring divide.

module md_ripple_adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[W];
endmodule

module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic        sa_q;
  logic        sb_q;
  logic        bzero_q;
  logic [31:0] a_orig_q;
  logic [31:0] opnd_q;   // multiplicand |a| for multiply, divisor |b| for divide
  logic [31:0] ph_q;     // product high half / partial remainder
  logic [31:0] pl_q;     // multiplier bits / quotient bits
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        dbz_q;

  // Operand conditioning at start
  logic        sa_in;
  logic        sb_in;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    sa_in = op[0] & a[31];
    sb_in = op[0] & b[31];
    abs_a = sa_in ? (32'd0 - a) : a;
    abs_b = sb_in ? (32'd0 - b) : b;
  end

  // Shared iteration adder
  logic        is_div;
  logic [32:0] add_a;
  logic [32:0] add_b;
  logic        add_cin;
  logic [32:0] add_sum;
  logic        add_cout;

  assign is_div = op_q[1];

  always_comb begin
    add_a   = {1'b0, ph_q};
    add_b   = 33'd0;
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {ph_q, pl_q[31]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else if (pl_q[0]) begin
      add_b   = {1'b0, opnd_q};
    end
  end

  md_ripple_adder #(.W(33)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  logic [31:0] ph_d;
  logic [31:0] pl_d;

  // A carry out of R + ~D + 1 means no borrow, i.e. the trial remainder is non-negative
  always_comb begin
    ph_d = add_sum[32:1];
    pl_d = {add_sum[0], pl_q[31:1]};
    if (is_div) begin
      if (add_cout) begin
        ph_d = add_sum[31:0];
        pl_d = {pl_q[30:0], 1'b1};
      end else begin
        ph_d = add_a[31:0];
        pl_d = {pl_q[30:0], 1'b0};
      end
    end
  end

  // Sign fixup and result selection for FINISH
  logic [63:0] prod;
  logic [63:0] prod_neg;
  logic [31:0] q_neg;
  logic [31:0] r_neg;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    prod     = {ph_q, pl_q};
    prod_neg = 64'd0 - prod;
    q_neg    = 32'd0 - pl_q;
    r_neg    = 32'd0 - ph_q;
    res_hi   = ph_q;
    res_lo   = pl_q;
    case (op_q)
      2'b01: begin
        if (sa_q ^ sb_q) begin
          res_hi = prod_neg[63:32];
          res_lo = prod_neg[31:0];
        end
      end
      2'b10, 2'b11: begin
        if (bzero_q) begin
          res_hi = a_orig_q;
          res_lo = 32'hFFFF_FFFF;
        end else if (op_q[0]) begin
          res_lo = (sa_q ^ sb_q) ? q_neg : pl_q;
          res_hi = sa_q ? r_neg : ph_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      a_orig_q <= 32'd0;
      opnd_q   <= 32'd0;
      ph_q     <= 32'd0;
      pl_q     <= 32'd0;
      cnt_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q     <= op;
            sa_q     <= sa_in;
            sb_q     <= sb_in;
            bzero_q  <= (b == 32'd0);
            a_orig_q <= a;
            opnd_q   <= op[1] ? abs_b : abs_a;
            pl_q     <= op[1] ? abs_a : abs_b;
            ph_q     <= 32'd0;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          ph_q  <= ph_d;
          pl_q  <= pl_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= S_FINISH;
        end
        S_FINISH: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          dbz_q   <= is_div & bzero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vectors and protocol sequences for mult_div_unit

module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen; returns at the done negedge.
  task automatic wait_done(output int bcnt);
    int guard;
    guard = 0;
    bcnt  = 0;
    while (done !== 1'b1 && guard < 60) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      guard++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int bc;
    int dcount;

    vt[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1]  = '{OP_MULT,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vt[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vt[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[6]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vt[7]  = '{OP_MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0};
    vt[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vt[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vt[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vt[11] = '{OP_MULT,  32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      start_op(vt[i].op, vt[i].a, vt[i].b);
      wait_done(bc);
      chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vt[i].dbz});
      chk($sformatf("v%0d_busy_cycles", i), bc, 32'd33);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), {31'd0, done}, 32'd0);
    end

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h11112222;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    chk("mthi", hi, 32'h11112222);
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo, 32'hA5A5A5A5);

    // Stray start and MTHI during RUN are ignored; HI/LO hold
    start_op(OP_MULTU, 32'd2, 32'd3);
    repeat (9) @(negedge clk);
    chk("run_hold_hi", hi, 32'h11112222);
    chk("run_hold_lo", lo, 32'hA5A5A5A5);
    start = 1'b1; op = OP_DIVU; a = 32'd99; b = 32'd1;
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("run_ignore_we", hi, 32'h11112222);
    wait_done(bc);
    chk("prot_hi", hi, 32'd0);
    chk("prot_lo", lo, 32'd6);
    chk("prot_busy_cycles", bc, 32'd23);

    // Back-to-back: start in the done cycle, together with an MTLO
    lo_we = 1'b1; wdata = 32'h0BADF00D;
    start_op(OP_MULTU, 32'd7, 32'd9);
    lo_we = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    chk("same_cycle_write", lo, 32'h0BADF00D);
    wait_done(bc);
    chk("b2b_lo", lo, 32'd63);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_busy_cycles", bc, 32'd33);
    @(negedge clk);

    // Reset mid-divide
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("abort_no_done", dcount, 32'd0);
    start_op(OP_MULTU, 32'd2, 32'd3);
    wait_done(bc);
    chk("post_reset_lo", lo, 32'd6);
    chk("post_reset_hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
